// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t     : arbiter FSM encoding (IDLE, BURST)
//   DEF_DATA_W      : default word width, matches the fifo data_in width
//   FIFO_DEPTH      : entries in the downstream fifo
//   FIFO_FULL_LVL   : occupancy at which the fifo raises full; the arbiter
//                     stops writing as soon as full is seen
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int FIFO_DEPTH    = 64;
  localparam int FIFO_FULL_LVL = 63;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker (purely combinational).
//   req   : request vector, one bit per producer
//   base  : index holding highest priority this round
//   valid : at least one request is asserted
//   idx   : first asserted request searching base, base+1, ... mod N_REQ
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] base,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotate so that bit 0 is the producer at base; the doubled vector makes
    // the rotation a plain shift.
    rot   = N_REQ'({req, req} >> base);
    valid = |req;
    idx   = '0;
    sum   = '0;
    // Descending scan: the lowest set offset is written last and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, base} + (IDX_W + 1)'(k);
        if (sum >= N_W) begin
          sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single fifo write port among N_REQ
// producers, one bounded burst per grant.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-producer request (word valid on req_data while high)
//   req_data   : producer words, producer i at [i*DATA_W +: DATA_W]
//   ack        : per-producer accept; a word moves when req[i] & ack[i]
//   fifo_full  : fifo full flag (registered inside the fifo)
//   fifo_wr_en : fifo write enable
//   fifo_data  : fifo write data (owner's slice)
//   owner      : current or last grant holder
//   busy       : high while a burst is in progress
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]  OWNER_LAST = IDX_W'(N_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(MAX_BURST - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  owner_nxt, rr_ptr, rr_ptr_nxt, rr_next, pick_idx;
  logic [BEAT_W-1:0] beats, beats_nxt;
  logic              pick_valid, own_req, xfer;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .base  (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner's request and data; loops with compares keep the select legal for
  // non-power-of-two N_REQ.
  always_comb begin
    own_req   = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_req   = req[i];
        fifo_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A stalled burst keeps its grant: full only masks the transfer.
  assign xfer       = (state == BURST) && own_req && !fifo_full;
  assign fifo_wr_en = xfer;
  assign busy       = (state == BURST);
  assign rr_next    = (owner == OWNER_LAST) ? '0 : owner + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = xfer && (owner == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    beats_nxt  = beats;
    case (state)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          owner_nxt = pick_idx;
          beats_nxt = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          beats_nxt = beats + BEAT_W'(1);
        end
        // Release on the last beat of the burst or as soon as the owner
        // withdraws, even while the fifo is full.
        if (!own_req || (xfer && (beats == BEAT_LAST))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = rr_next;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      beats  <= beats_nxt;
    end
  end

endmodule
